dmem_responder: RTL

- Responder end of the CPU data-memory bus: services load/store requests from the mips core's data port.
- Handshake is request/ready with a programmable number of wait states.
- Byte-lane writes use the core's 4-bit `sel`.
- Holds a word-addressed RAM and flags accesses outside its window, so slow or mapped memory can replace the zero-latency data memory.

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_bytelane_ram.sv | 50 +++++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = DATA_W / LANES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Wait counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
module dmem_bytelane_ram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      wr_be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Contents are deliberately left unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_be[i]) begin
                mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read register holds between loads; rd_clr forces zero for rejected accesses.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = rd_clr ? '0 : mem_q[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus responder: request/ready handshake with programmable wait
// states, byte-lane stores into a local RAM and out-of-window error flagging.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              memwrite,
    input  logic [LANES-1:0]  sel,
    input  logic [31:0]       dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int unsigned CNT_W        = cnt_width(WAIT_CYCLES);
    localparam int unsigned CNT_LOAD_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_INT);
    localparam logic [32:0] WINDOW_BYTES  = 33'(1) << (ADDR_WIDTH + 2);
    localparam bit          ZERO_WAIT     = (WAIT_CYCLES == 0);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [LANES-1:0]        sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    oob_q, oob_d;
    logic                    mem_ready_q, mem_ready_d;
    logic                    mem_err_q, mem_err_d;

    logic [31:0]             off_c;
    logic                    oob_c;
    logic                    commit_c;
    logic                    cm_we_c;
    logic [LANES-1:0]        cm_sel_c;
    logic [ADDR_WIDTH-1:0]   cm_idx_c;
    logic [DATA_W-1:0]       cm_wdata_c;
    logic                    cm_oob_c;
    logic [LANES-1:0]        ram_be_c;
    logic                    ram_rd_en_c;

    // Modular offset from the window base; wrap below BASE_ADDR lands out of window.
    always_comb begin
        off_c = dataadr - BASE_ADDR;
        oob_c = ({1'b0, off_c} >= WINDOW_BYTES);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        sel_d       = sel_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        oob_d       = oob_q;
        commit_c    = 1'b0;
        cm_we_c     = we_q;
        cm_sel_c    = sel_q;
        cm_idx_c    = idx_q;
        cm_wdata_c  = wdata_q;
        cm_oob_c    = oob_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    we_d    = memwrite;
                    sel_d   = sel;
                    idx_d   = off_c[ADDR_WIDTH+1:2];
                    wdata_d = writedata;
                    oob_d   = oob_c;
                    if (ZERO_WAIT) begin
                        // With no wait states the accept edge is also the commit edge.
                        state_d    = ST_RESP;
                        commit_c   = 1'b1;
                        cm_we_c    = memwrite;
                        cm_sel_c   = sel;
                        cm_idx_c   = off_c[ADDR_WIDTH+1:2];
                        cm_wdata_c = writedata;
                        cm_oob_c   = oob_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_ready_d = commit_c;
        mem_err_d   = commit_c & cm_oob_c;
    end

    // Reset gates the RAM strobes so an aborted transaction never commits.
    always_comb begin
        ram_be_c    = '0;
        ram_rd_en_c = 1'b0;
        if (commit_c && !rst) begin
            if (cm_we_c) begin
                ram_be_c = cm_oob_c ? '0 : cm_sel_c;
            end else begin
                ram_rd_en_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            oob_q       <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            oob_q       <= oob_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
        end
    end

    dmem_bytelane_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_be  (ram_be_c),
        .addr   (cm_idx_c),
        .wdata  (cm_wdata_c),
        .rd_en  (ram_rd_en_c),
        .rd_clr (cm_oob_c),
        .rdata  (readdata)
    );

    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;

endmodule
